pc_gen: RTL and testbench

Parametrised fetch-stage program-counter generator. It supersedes the fixed 32-bit PC with its single redirect.
- Adds a configurable reset vector and width.
- Holds a pending redirect across stall cycles.
- Provides exception entry to a fixed vector with an EPC register, and ERET return.
- Sits between the fetch stage (drives IM address) and decode/exception logic (supplies redirects).

---
 rtl/pc_gen.sv | 114 +++++++++++
 tb/tb_pc_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: reset vector, stall-held pending redirect,
// exception entry/EPC/ERET. Optional misaligned-target trap enabled by PC_ALIGN_CHK_EN.
module pc_gen #(
    parameter int unsigned           WIDTH    = 32,
    parameter logic [WIDTH-1:0]      RESET_PC = 32'h0000_3000,
    parameter logic [WIDTH-1:0]      EXC_VEC  = 32'h0000_4180,
    parameter int unsigned           STEP     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             change,
    input  logic [WIDTH-1:0] npc,
    input  logic             exc_req,
    input  logic [WIDTH-1:0] exc_epc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_4add,
    output logic [WIDTH-1:0] epc,
    output logic             in_exc,
`ifdef PC_ALIGN_CHK_EN
    output logic             align_err,
`endif
    output logic             pend_vld
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
`ifdef PC_ALIGN_CHK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - WIDTH'(1);
`endif

    logic [WIDTH-1:0] pc_d, pc_q;
    logic [WIDTH-1:0] epc_d, epc_q;
    logic [WIDTH-1:0] pend_npc_d, pend_npc_q;
    logic             in_exc_d, in_exc_q;
    logic             pend_vld_d, pend_vld_q;
    logic             align_err_d, align_err_q;
    logic [WIDTH-1:0] tgt;

    assign pc_4add = pc_q + STEP_W;

    always_comb begin
        pc_d        = pc_q;
        epc_d       = epc_q;
        pend_npc_d  = pend_npc_q;
        in_exc_d    = in_exc_q;
        pend_vld_d  = pend_vld_q;
        align_err_d = 1'b0;
        // A live redirect always wins over one parked during a stall.
        tgt         = change ? npc : pend_npc_q;

        if (exc_req) begin
            pc_d       = EXC_VEC;
            epc_d      = exc_epc;
            in_exc_d   = 1'b1;
            pend_vld_d = 1'b0;
        end else if (eret) begin
            pc_d       = epc_q;
            in_exc_d   = 1'b0;
            pend_vld_d = 1'b0;
        end else if (stall) begin
            if (change) begin
                pend_npc_d = npc;
                pend_vld_d = 1'b1;
            end
        end else if (change || pend_vld_q) begin
            pend_vld_d = 1'b0;
`ifdef PC_ALIGN_CHK_EN
            if ((tgt & ALIGN_MASK) != '0) begin
                pc_d        = EXC_VEC;
                epc_d       = tgt;
                in_exc_d    = 1'b1;
                align_err_d = 1'b1;
            end else begin
                pc_d = tgt;
            end
`else
            pc_d = tgt;
`endif
        end else begin
            pc_d = pc_4add;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            epc_q       <= '0;
            pend_npc_q  <= '0;
            in_exc_q    <= 1'b0;
            pend_vld_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            pend_npc_q  <= pend_npc_d;
            in_exc_q    <= in_exc_d;
            pend_vld_q  <= pend_vld_d;
            align_err_q <= align_err_d;
        end
    end

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign in_exc   = in_exc_q;
    assign pend_vld = pend_vld_q;
`ifdef PC_ALIGN_CHK_EN
    assign align_err = align_err_q;
`else
    logic unused_align;
    assign unused_align = align_err_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, stall, change, exc_req, eret;
    logic [31:0] npc, exc_epc;
    logic [31:0] pc, pc_4add, epc;
    logic        in_exc, pend_vld;
`ifdef PC_ALIGN_CHK_EN
    logic        align_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .change   (change),
        .npc      (npc),
        .exc_req  (exc_req),
        .exc_epc  (exc_epc),
        .eret     (eret),
        .pc       (pc),
        .pc_4add  (pc_4add),
        .epc      (epc),
        .in_exc   (in_exc),
`ifdef PC_ALIGN_CHK_EN
        .align_err(align_err),
`endif
        .pend_vld (pend_vld)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] exp);
        chk(tag, pc, exp);
        chk({tag, "_4add"}, pc_4add, exp + 32'd4);
    endtask

    initial begin
        reset = 1; stall = 0; change = 0; exc_req = 0; eret = 0;
        npc = '0; exc_epc = '0;
        step(); step();
        chk_pc("rst_pc", 32'h3000);
        chk("rst_epc", epc, 0);
        chk("rst_inexc", {31'd0, in_exc}, 0);
        chk("rst_pend", {31'd0, pend_vld}, 0);
        reset = 0;
        step(); chk_pc("seq1", 32'h3004);
        step(); chk_pc("seq2", 32'h3008);

        // stall hold
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_pc("stall_hold", 32'h3008);
        end
        stall = 0;
        step(); chk_pc("stall_rel", 32'h300C);
        step(); chk_pc("seq3", 32'h3010);

        // pending redirect, newest wins
        stall = 1; change = 1; npc = 32'h3100;
        step(); chk_pc("pend1_pc", 32'h3010); chk("pend1_vld", {31'd0, pend_vld}, 1);
        npc = 32'h3200;
        step(); chk_pc("pend2_pc", 32'h3010); chk("pend2_vld", {31'd0, pend_vld}, 1);
        stall = 0; change = 0;
        step(); chk_pc("pend_apply", 32'h3200); chk("pend_clr", {31'd0, pend_vld}, 0);
        step(); chk_pc("pend_after", 32'h3204);

        // live change beats pending
        stall = 1; change = 1; npc = 32'h3300;
        step(); chk("live_pend", {31'd0, pend_vld}, 1);
        stall = 0; npc = 32'h3500;
        step(); chk_pc("live_wins", 32'h3500); chk("live_clr", {31'd0, pend_vld}, 0);
        change = 0;

        // exception over stall+change
        stall = 1; change = 1; npc = 32'h3400; exc_req = 1; exc_epc = 32'h3020;
        step();
        chk_pc("exc_pc", 32'h4180);
        chk("exc_epc", epc, 32'h3020);
        chk("exc_inexc", {31'd0, in_exc}, 1);
        chk("exc_pend", {31'd0, pend_vld}, 0);
        stall = 0; change = 0; exc_req = 0;
        step(); chk_pc("exc_seq", 32'h4184);

        // pending set while in_exc, then eret drops it
        stall = 1; change = 1; npc = 32'h3600;
        step(); chk("inexc_pend", {31'd0, pend_vld}, 1); chk("inexc_flag", {31'd0, in_exc}, 1);
        change = 0; eret = 1;
        step(); chk_pc("eret_pc", 32'h3020);
        chk("eret_inexc", {31'd0, in_exc}, 0);
        chk("eret_pend", {31'd0, pend_vld}, 0);
        stall = 0; eret = 0;
        step(); chk_pc("eret_seq", 32'h3024);

        // wrap
        change = 1; npc = 32'hFFFF_FFFC;
        step(); chk_pc("wrap_top", 32'hFFFF_FFFC);
        change = 0;
        step(); chk_pc("wrap_zero", 32'h0000_0000);

        // nested exception overwrites epc; eret with in_exc=0 still loads epc
        exc_req = 1; exc_epc = 32'h1111_0000;
        step(); chk("nest1_epc", epc, 32'h1111_0000);
        exc_epc = 32'h2222_0000;
        step(); chk("nest2_epc", epc, 32'h2222_0000); chk_pc("nest2_pc", 32'h4180);
        exc_req = 0; eret = 1;
        step(); chk_pc("eret1", 32'h2222_0000); chk("eret1_inexc", {31'd0, in_exc}, 0);
        step(); chk_pc("eret2", 32'h2222_0000);
        eret = 0;

        // reset drops a pending redirect
        stall = 1; change = 1; npc = 32'h3700;
        step(); chk("rst_mid_pend", {31'd0, pend_vld}, 1);
        reset = 1;
        step(); chk_pc("rst_mid_pc", 32'h3000); chk("rst_mid_vld", {31'd0, pend_vld}, 0);
        chk("rst_mid_epc", epc, 0);
        reset = 0; stall = 0; change = 0;
        step(); chk_pc("rst_mid_seq", 32'h3004);

        // misaligned target
        change = 1; npc = 32'h3102;
        step();
`ifdef PC_ALIGN_CHK_EN
        chk_pc("algn_pc", 32'h4180);
        chk("algn_epc", epc, 32'h3102);
        chk("algn_inexc", {31'd0, in_exc}, 1);
        chk("algn_err", {31'd0, align_err}, 1);
        change = 0;
        step(); chk("algn_err_clr", {31'd0, align_err}, 0); chk_pc("algn_seq", 32'h4184);
`else
        chk_pc("algn_nochk", 32'h3102);
        chk("algn_nochk_inexc", {31'd0, in_exc}, 0);
        change = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
